// File: rtl/fp_sign_exc_pipe.sv
// fp_sign_exc_pipe
//   Sign and special-value pipeline for the floating-point multiply/divide
//   datapath. A combinational classifier works out the result sign, the
//   result class (normal/zero/inf/NaN) and the invalid / divide-by-zero
//   flags. The result is then delayed by DEPTH enabled cycles so it lines up
//   with the mantissa/exponent path. Each stage carries a valid bit, the
//   pipeline can be flushed synchronously, and occupancy is reported.
//
// Parameters
//   DEPTH     number of stages (enabled edges from input to output), 1..64
//   CW        width of the occupancy count (derived)
//
// Ports
//   clk       rising-edge clock
//   arst      asynchronous active-high reset, clears all state
//   en        advance enable; when low every stage and the count hold
//   flush     synchronous clear of every stage, wins over en
//   in_valid  operand sign/class inputs are valid this cycle
//   op        0 = multiply, 1 = divide
//   s_a, s_b  operand signs
//   cls_a/b   operand class: 00 normal, 01 zero, 10 inf, 11 NaN
//   out_valid output stage holds a valid result
//   s_r       result sign (0 for NaN results)
//   cls_r     result class
//   invalid   NaN generated by this operation (not propagated)
//   div_zero  finite nonzero value divided by zero
//   count     number of valid entries across all stages
//   busy      count != 0
module fp_sign_exc_pipe #(
    parameter int DEPTH = 23,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          en,
    input  logic          flush,
    input  logic          in_valid,
    input  logic          op,
    input  logic          s_a,
    input  logic          s_b,
    input  logic [1:0]    cls_a,
    input  logic [1:0]    cls_b,
    output logic          out_valid,
    output logic          s_r,
    output logic [1:0]    cls_r,
    output logic          invalid,
    output logic          div_zero,
    output logic [CW-1:0] count,
    output logic          busy
);

    localparam logic [1:0] CLS_NORM = 2'b00;
    localparam logic [1:0] CLS_ZERO = 2'b01;
    localparam logic [1:0] CLS_INF  = 2'b10;
    localparam logic [1:0] CLS_NAN  = 2'b11;

    typedef struct packed {
        logic       vld;
        logic       s;
        logic [1:0] cls;
        logic       inv;
        logic       dz;
    } entry_t;

    // Result classification for one operation. Sign is forced to 0 for any
    // NaN result so the NaN leaving this block is always canonical.
    function automatic entry_t classify(
        input logic       is_div,
        input logic       sa,
        input logic       sb,
        input logic [1:0] ca,
        input logic [1:0] cb
    );
        entry_t r;
        logic   nan_in;
        r      = '0;
        r.vld  = 1'b1;
        nan_in = (ca == CLS_NAN) || (cb == CLS_NAN);
        if (!is_div) begin
            if (nan_in) begin
                r.cls = CLS_NAN;
            end else if ((ca == CLS_INF && cb == CLS_ZERO) ||
                         (ca == CLS_ZERO && cb == CLS_INF)) begin
                r.cls = CLS_NAN;
                r.inv = 1'b1;
            end else if (ca == CLS_INF || cb == CLS_INF) begin
                r.cls = CLS_INF;
            end else if (ca == CLS_ZERO || cb == CLS_ZERO) begin
                r.cls = CLS_ZERO;
            end else begin
                r.cls = CLS_NORM;
            end
        end else begin
            if (nan_in) begin
                r.cls = CLS_NAN;
            end else if ((ca == CLS_ZERO && cb == CLS_ZERO) ||
                         (ca == CLS_INF && cb == CLS_INF)) begin
                r.cls = CLS_NAN;
                r.inv = 1'b1;
            end else if (ca == CLS_NORM && cb == CLS_ZERO) begin
                r.cls = CLS_INF;
                r.dz  = 1'b1;
            end else if (ca == CLS_INF) begin
                // divisor is normal or zero here; inf/inf was caught above
                r.cls = CLS_INF;
            end else if (cb == CLS_INF) begin
                r.cls = CLS_ZERO;
            end else if (ca == CLS_ZERO) begin
                r.cls = CLS_ZERO;
            end else begin
                r.cls = CLS_NORM;
            end
        end
        r.s = (r.cls == CLS_NAN) ? 1'b0 : (sa ^ sb);
        return r;
    endfunction

    entry_t          entry_p0;
    entry_t          pipe_p [DEPTH];
    logic   [CW-1:0] count_next;

    // An idle input slot loads an all-zero payload so result outputs read 0
    // whenever out_valid is low.
    always_comb begin
        entry_p0 = '0;
        if (in_valid) begin
            entry_p0 = classify(op, s_a, s_b, cls_a, cls_b);
        end
    end

    // Entry and exit on the same edge cancel; a full pipe always has a valid
    // output stage, so the count cannot pass DEPTH.
    assign count_next = count + CW'(in_valid) - CW'(pipe_p[DEPTH-1].vld);

    // ---- stage 0 load and shift toward stage DEPTH-1 ----
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int k = 0; k < DEPTH; k++) begin
                pipe_p[k] <= '0;
            end
            count <= '0;
            busy  <= 1'b0;
        end else if (flush) begin
            for (int k = 0; k < DEPTH; k++) begin
                pipe_p[k] <= '0;
            end
            count <= '0;
            busy  <= 1'b0;
        end else if (en) begin
            pipe_p[0] <= entry_p0;
            for (int k = 1; k < DEPTH; k++) begin
                pipe_p[k] <= pipe_p[k-1];
            end
            count <= count_next;
            busy  <= (count_next != '0);
        end
    end

    // ---- output stage ----
    assign out_valid = pipe_p[DEPTH-1].vld;
    assign s_r       = pipe_p[DEPTH-1].s;
    assign cls_r     = pipe_p[DEPTH-1].cls;
    assign invalid   = pipe_p[DEPTH-1].inv;
    assign div_zero  = pipe_p[DEPTH-1].dz;

endmodule

// File: tb/tb_fp_sign_exc_pipe.sv
// tb_fp_sign_exc_pipe
//   Directed self-checking bench for fp_sign_exc_pipe at DEPTH=23.
module tb_fp_sign_exc_pipe;

    localparam int DEPTH = 23;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk;
    logic          arst;
    logic          en;
    logic          flush;
    logic          in_valid;
    logic          op;
    logic          s_a;
    logic          s_b;
    logic [1:0]    cls_a;
    logic [1:0]    cls_b;
    logic          out_valid;
    logic          s_r;
    logic [1:0]    cls_r;
    logic          invalid;
    logic          div_zero;
    logic [CW-1:0] count;
    logic          busy;

    int checks = 0;
    int errors = 0;

    fp_sign_exc_pipe #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .arst      (arst),
        .en        (en),
        .flush     (flush),
        .in_valid  (in_valid),
        .op        (op),
        .s_a       (s_a),
        .s_b       (s_b),
        .cls_a     (cls_a),
        .cls_b     (cls_b),
        .out_valid (out_valid),
        .s_r       (s_r),
        .cls_r     (cls_r),
        .invalid   (invalid),
        .div_zero  (div_zero),
        .count     (count),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Directed vectors with hand-computed results.
    typedef struct packed {
        logic       op;
        logic       sa;
        logic       sb;
        logic [1:0] ca;
        logic [1:0] cb;
        logic       es;
        logic [1:0] ecls;
        logic       einv;
        logic       edz;
    } vec_t;

    vec_t tbl [9];

    typedef struct {
        int age;
        int idx;
    } inflight_t;

    task automatic init_table();
        //            op    sa    sb    ca     cb     es    ecls   inv   dz
        tbl[0] = '{1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0}; // mul N*N
        tbl[1] = '{1'b1, 1'b0, 1'b1, 2'b00, 2'b01, 1'b1, 2'b10, 1'b0, 1'b1}; // div N/0
        tbl[2] = '{1'b1, 1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 2'b11, 1'b1, 1'b0}; // div 0/0
        tbl[3] = '{1'b1, 1'b0, 1'b1, 2'b00, 2'b10, 1'b1, 2'b01, 1'b0, 1'b0}; // div N/inf
        tbl[4] = '{1'b0, 1'b1, 1'b1, 2'b10, 2'b01, 1'b0, 2'b11, 1'b1, 1'b0}; // mul inf*0
        tbl[5] = '{1'b0, 1'b1, 1'b0, 2'b11, 2'b00, 1'b0, 2'b11, 1'b0, 1'b0}; // mul NaN*N
        tbl[6] = '{1'b1, 1'b1, 1'b0, 2'b10, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0}; // div inf/N
        tbl[7] = '{1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b1, 2'b01, 1'b0, 1'b0}; // mul 0*N
        tbl[8] = '{1'b1, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 2'b11, 1'b1, 1'b0}; // div inf/inf
    endtask

    task automatic drive_vec(input int i);
        op    = tbl[i].op;
        s_a   = tbl[i].sa;
        s_b   = tbl[i].sb;
        cls_a = tbl[i].ca;
        cls_b = tbl[i].cb;
    endtask

    function automatic logic [5:0] exp_of(input int i);
        return {1'b1, tbl[i].es, tbl[i].ecls, tbl[i].einv, tbl[i].edz};
    endfunction

    // Issue one vector and advance until it sits in the output stage.
    // Entered and left just after a rising edge.
    task automatic advance(input int i);
        drive_vec(i);
        in_valid = 1'b1;
        en       = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (DEPTH - 1) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if ({s_r, cls_r, invalid, div_zero} !== 5'b0) begin
            errors++; $display("FAIL reset_payload: got %b expected 00000", {s_r, cls_r, invalid, div_zero});
        end
        checks++;
        if (count !== '0) begin
            errors++; $display("FAIL reset_count: got %0d expected 0", count);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        arst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency();
        drive_vec(0);
        in_valid = 1'b1;
        en       = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (count !== CW'(1) || busy !== 1'b1) begin
            errors++; $display("FAIL lat_count_in: got count=%0d busy=%b expected 1/1", count, busy);
        end
        repeat (DEPTH - 2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL lat_early: got out_valid=%b expected 0 after %0d edges", out_valid, DEPTH - 1);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, s_r, cls_r, invalid, div_zero} !== 6'b110000) begin
            errors++; $display("FAIL lat_result: got %b expected 110000", {out_valid, s_r, cls_r, invalid, div_zero});
        end
        checks++;
        if (count !== CW'(1)) begin
            errors++; $display("FAIL lat_count_out: got %0d expected 1", count);
        end
        @(posedge clk);
        #1;
        checks++;
        if (count !== '0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL lat_exit: got count=%0d busy=%b out_valid=%b expected 0/0/0", count, busy, out_valid);
        end
    endtask

    task automatic test_divide();
        int ids [5] = '{1, 2, 3, 6, 8};
        foreach (ids[j]) begin
            advance(ids[j]);
            checks++;
            if ({out_valid, s_r, cls_r, invalid, div_zero} !== exp_of(ids[j])) begin
                errors++;
                $display("FAIL div_vec%0d: got %b expected %b", ids[j],
                         {out_valid, s_r, cls_r, invalid, div_zero}, exp_of(ids[j]));
            end
        end
    endtask

    task automatic test_multiply();
        int ids [3] = '{4, 5, 7};
        foreach (ids[j]) begin
            advance(ids[j]);
            checks++;
            if ({out_valid, s_r, cls_r, invalid, div_zero} !== exp_of(ids[j])) begin
                errors++;
                $display("FAIL mul_vec%0d: got %b expected %b", ids[j],
                         {out_valid, s_r, cls_r, invalid, div_zero}, exp_of(ids[j]));
            end
        end
    endtask

    task automatic test_back_to_back();
        inflight_t  q[$];
        int         sent = 0;
        int         max_count = 0;
        logic       en_now;
        logic       v_now;
        logic [5:0] exp;
        en       = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            en_now   = (cyc % 2 == 0);
            v_now    = (sent < 30);
            en       = en_now;
            in_valid = v_now;
            drive_vec(sent % 9);
            @(posedge clk);
            if (en_now) begin
                foreach (q[j]) q[j].age++;
                while (q.size() > 0 && q[0].age > DEPTH) void'(q.pop_front());
                if (v_now) begin
                    q.push_back('{1, sent % 9});
                    sent++;
                end
            end
            #1;
            if (q.size() > max_count) max_count = q.size();
            checks++;
            if (count !== CW'(q.size())) begin
                errors++; $display("FAIL b2b_count cyc%0d: got %0d expected %0d", cyc, count, q.size());
            end
            exp = 6'b0;
            if (q.size() > 0 && q[0].age == DEPTH) exp = exp_of(q[0].idx);
            checks++;
            if ({out_valid, s_r, cls_r, invalid, div_zero} !== exp) begin
                errors++;
                $display("FAIL b2b_out cyc%0d: got %b expected %b", cyc,
                         {out_valid, s_r, cls_r, invalid, div_zero}, exp);
            end
            if (sent == 30 && q.size() == 0) break;
        end
        checks++;
        if (sent != 30 || q.size() != 0) begin
            errors++; $display("FAIL b2b_drain: got sent=%0d left=%0d expected 30/0", sent, q.size());
        end
        checks++;
        if (max_count != DEPTH) begin
            errors++; $display("FAIL b2b_saturate: got max count %0d expected %0d", max_count, DEPTH);
        end
        en       = 1'b1;
        in_valid = 1'b0;
    endtask

    task automatic test_flush();
        logic seen;
        en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            drive_vec(k % 9);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++;
        if (count !== CW'(10)) begin
            errors++; $display("FAIL flush_fill: got count=%0d expected 10", count);
        end
        in_valid = 1'b1;
        en       = 1'b0;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (count !== '0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_clear: got count=%0d busy=%b out_valid=%b expected 0/0/0", count, busy, out_valid);
        end
        en   = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || count !== '0) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL flush_ghost: got leftover activity=%b expected 0", seen);
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1;
        for (int k = 0; k < 25; k++) begin
            drive_vec(k % 9);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        checks++;
        if (count !== CW'(DEPTH) || out_valid !== 1'b1) begin
            errors++; $display("FAIL arst_pre: got count=%0d out_valid=%b expected %0d/1", count, out_valid, DEPTH);
        end
        #2;
        arst = 1'b1;
        #1;
        checks++;
        if ({out_valid, s_r, cls_r, invalid, div_zero} !== 6'b0) begin
            errors++; $display("FAIL arst_outputs: got %b expected 000000", {out_valid, s_r, cls_r, invalid, div_zero});
        end
        checks++;
        if (count !== '0 || busy !== 1'b0) begin
            errors++; $display("FAIL arst_count: got count=%0d busy=%b expected 0/0", count, busy);
        end
        #1;
        arst     = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (count !== '0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL arst_after: got count=%0d out_valid=%b expected 0/0", count, out_valid);
        end
        advance(6);
        checks++;
        if ({out_valid, s_r, cls_r, invalid, div_zero} !== exp_of(6)) begin
            errors++; $display("FAIL arst_resume: got %b expected %b", {out_valid, s_r, cls_r, invalid, div_zero}, exp_of(6));
        end
    endtask

    initial begin
        arst     = 1'b1;
        en       = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        op       = 1'b0;
        s_a      = 1'b0;
        s_b      = 1'b0;
        cls_a    = 2'b00;
        cls_b    = 2'b00;
        init_table();
        test_reset();
        test_latency();
        test_divide();
        test_multiply();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fp_sign_exc_pipe.md
# fp_sign_exc_pipe

Parametrised sign and special-value pipeline for the floating-point multiply/divide datapath. It computes the result sign and the result class (normal/zero/inf/NaN) for both operations, together with the invalid and divide-by-zero flags. The result is delayed by a configurable number of enabled cycles so it arrives aligned with the mantissa/exponent path. Unlike the fixed 23-stage sign-only delay line, it carries a valid bit per stage and supports a synchronous flush, and it reports pipeline occupancy.

## Interface
- DEPTH, 23, number of pipeline stages (enabled edges from input to output); legal range 1..64
- CW, $clog2(DEPTH+1), width of the occupancy count (derived; not overridden)
- clk  in  1  clock; all state updates on the rising edge
- arst  in  1  reset, asynchronous, active-high; clears all state
- en  in  1  pipeline advance enable; when 0, all state holds
- flush  in  1  synchronous clear of all stages; acts regardless of en
- in_valid  in  1  the operand sign/class inputs are valid this cycle
- op  in  1  0 = multiply, 1 = divide
- s_a, s_b  in  1 each  operand signs
- cls_a, cls_b  in  2 each  operand class: 00 normal, 01 zero, 10 inf, 11 NaN
- out_valid  out  1  the output stage holds a valid result
- s_r  out  1  result sign
- cls_r  out  2  result class, same encoding as the inputs
- invalid  out  1  the NaN was generated by this operation (not propagated)
- div_zero  out  1  finite nonzero value divided by zero
- count  out  CW  number of valid entries across all DEPTH stages
- busy  out  1  count != 0

## Operation
- Stage 0 is loaded from combinational classification logic. Stages 1..DEPTH-1 shift toward the output. Stage DEPTH-1 drives all result outputs directly (registered outputs).
- Classification for multiply:
  - Either operand NaN -> NaN.
  - inf×zero (either order) -> NaN, invalid=1.
  - Either operand inf -> inf.
  - Either operand zero -> zero.
  - Otherwise -> normal.
- Classification for divide:
  - Either operand NaN -> NaN.
  - 0/0 or inf/inf -> NaN, invalid=1.
  - normal/0 -> inf, div_zero=1.
  - inf/(normal or zero) -> inf.
  - (normal or zero)/inf -> zero.
  - 0/normal -> zero.
  - normal/normal -> normal.
- Sign: s_a^s_b, except a NaN result forces s_r=0 (canonical NaN).
- When in_valid=0, stage 0 loads an all-zero payload (valid=0, s=0, cls=00, flags=0). Result outputs are therefore 0 whenever out_valid=0.
- Priority order: arst > flush > en.
  - flush=1: every stage clears to zero and count becomes 0. Any in_valid presented in the same cycle is dropped.
  - en=0, no flush: all stages and count hold. in_valid is ignored.
- Count update when en=1 and no flush: count_next = count + in_valid − valid(stage DEPTH-1). Simultaneous entry and exit leaves count unchanged. Count never exceeds DEPTH.

## Timing
- Reset values: out_valid, s_r, cls_r, invalid, div_zero, count and busy are all 0. Every stage is 0.
- Latency: an input sampled at an enabled edge appears at the outputs after exactly DEPTH enabled edges. Cycles with en=0 stretch the latency by one each.
- Throughput: one result per enabled cycle. There is no backpressure; en is the only stall.
- DEPTH=1: the output stage is stage 0, and the result appears on the edge after it is sampled.
- arst mid-operation: all in-flight entries are lost immediately, with no partial outputs.
- busy and count are registered and change on the same edge as the stage contents.

## Test plan
- Reset, then with DEPTH=23 and en=1, present one multiply s_a=1, s_b=0, both normal -> out_valid=1, s_r=1, cls_r=00 exactly 23 edges later. count steps 0→1, then returns to 0 on the edge the entry exits.
- Divide cases:
  - cls_a=00, cls_b=01, s_a=0, s_b=1 -> cls_r=10, s_r=1, div_zero=1.
  - 0/0 -> cls_r=11, s_r=0, invalid=1.
  - normal/inf -> cls_r=01.
- Multiply inf×zero with s_a=1, s_b=1 -> cls_r=11, s_r=0, invalid=1. Multiply with a NaN input -> cls_r=11, invalid=0.
- Back-to-back stream of 30 valid inputs with en toggling 1,0 -> each result emerges after 23 enabled edges, in order. count saturates at 23 and holds during en=0 cycles.
- Fill with 10 entries, then assert flush together with in_valid=1 and en=0 -> next cycle count=0, busy=0, and no out_valid ever appears for those entries.
- Assert arst asynchronously mid-stream -> all outputs go to 0 before the next clock edge. Normal operation resumes after deassertion.
